// File: rtl/rpn_token_engine.sv
// RPN calculator core: turns keypad tokens into decimal entry, stack pushes/pops and arithmetic.
// Define RPN_MUL_EN to build the shift-add multiplier for key C; otherwise C is a no-op token.
module rpn_token_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_key_code,
    input  logic             i_key_valid,
    output logic [WIDTH-1:0] o_disp_value,
    output logic             o_disp_is_entry,
    output logic [3:0]       o_depth,
    output logic [1:0]       o_err,
    output logic             o_busy,
    output logic             o_op_done
);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);
    localparam int         EW      = WIDTH + 5;
    localparam int         CW      = $clog2(WIDTH + 1);

`ifdef RPN_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

    // What the DONE cycle does to the architectural state.
    typedef enum logic [2:0] {
        K_NONE, K_ENTRY, K_ECLR, K_PUSH, K_POP, K_REPL, K_BIN2, K_CLEAR
    } kind_t;

    state_t           r_state;
    logic             r_kv;
    logic             r_kv_d;
    logic [3:0]       r_kc;
    logic [3:0]       r_key;
    logic [WIDTH-1:0] r_stk [16];
    logic [3:0]       r_depth;
    logic [WIDTH-1:0] r_entry;
    logic             r_active;
    logic [1:0]       r_err;
    logic             r_busy;
    logic             r_op_done;
    logic [WIDTH-1:0] r_disp;
    logic             r_disp_ent;
    kind_t            r_p_kind;
    logic [WIDTH-1:0] r_p_val;
    logic [1:0]       r_p_err;
`ifdef RPN_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             w_is_mul;
`endif

    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_op_ok;
    logic             w_full;
    logic [EW-1:0]    w_ent_ext;
    logic             w_ent_ovf;
    kind_t            w_kind;
    logic [WIDTH-1:0] w_val;
    logic [1:0]       w_errn;

    logic [3:0]       w_depth_n;
    logic [WIDTH-1:0] w_entry_n;
    logic             w_active_n;
    logic             w_wr_en;
    logic [3:0]       w_wr_idx;
    logic [WIDTH-1:0] w_top_n;
    logic [WIDTH-1:0] w_disp_n;

    // Token decode: evaluated during EXEC from the latched key and current state.
    always_comb begin
        w_top     = (r_depth != 4'd0) ? r_stk[r_depth - 4'd1] : '0;
        w_next    = (r_depth >= 4'd2) ? r_stk[r_depth - 4'd2] : '0;
        w_op_a    = r_active ? w_top   : w_next;
        w_op_b    = r_active ? r_entry : w_top;
        w_op_ok   = r_active ? (r_depth >= 4'd1) : (r_depth >= 4'd2);
        w_full    = (r_depth == DEPTH_L);
        w_ent_ext = EW'(r_entry) * EW'(10) + EW'(r_key);
        w_ent_ovf = |w_ent_ext[EW-1:WIDTH];
        w_kind    = K_NONE;
        w_val     = '0;
        w_errn    = 2'd0;
`ifdef RPN_MUL_EN
        w_is_mul  = 1'b0;
`endif
        case (r_key)
            4'hA, 4'hB: begin
                if (!w_op_ok) begin
                    w_errn = 2'd2;
                end else begin
                    w_kind = r_active ? K_REPL : K_BIN2;
                    w_val  = (r_key == 4'hA) ? (w_op_a + w_op_b) : (w_op_a - w_op_b);
                end
            end
            4'hC: begin
`ifdef RPN_MUL_EN
                w_is_mul = 1'b1;
                if (!w_op_ok) begin
                    w_errn = 2'd2;
                end else begin
                    w_kind = r_active ? K_REPL : K_BIN2;
                end
`endif
            end
            4'hD: begin
                if (r_active) begin
                    w_kind = K_ECLR;
                end else if (r_depth == 4'd0) begin
                    w_errn = 2'd2;
                end else begin
                    w_kind = K_POP;
                end
            end
            4'hE: begin
                if (!r_active && r_depth == 4'd0) begin
                    w_errn = 2'd2;
                end else if (w_full) begin
                    w_errn = 2'd1;
                end else begin
                    w_kind = K_PUSH;
                    w_val  = r_active ? r_entry : w_top;
                end
            end
            4'hF: w_kind = K_CLEAR;
            default: begin
                if (!r_active) begin
                    w_kind = K_ENTRY;
                    w_val  = WIDTH'(r_key);
                end else if (w_ent_ovf) begin
                    w_errn = 2'd3;
                end else begin
                    w_kind = K_ENTRY;
                    w_val  = w_ent_ext[WIDTH-1:0];
                end
            end
        endcase
    end

    // Commit view: every stack write lands on the new top, so the display can use it directly.
    always_comb begin
        w_depth_n  = r_depth;
        w_entry_n  = r_entry;
        w_active_n = r_active;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_depth;
        case (r_p_kind)
            K_ENTRY: begin
                w_entry_n  = r_p_val;
                w_active_n = 1'b1;
            end
            K_ECLR: begin
                w_entry_n  = '0;
                w_active_n = 1'b0;
            end
            K_PUSH: begin
                w_wr_en    = 1'b1;
                w_depth_n  = r_depth + 4'd1;
                w_active_n = 1'b0;
            end
            K_POP: w_depth_n = r_depth - 4'd1;
            K_REPL: begin
                w_wr_en    = 1'b1;
                w_wr_idx   = r_depth - 4'd1;
                w_active_n = 1'b0;
            end
            K_BIN2: begin
                w_wr_en    = 1'b1;
                w_wr_idx   = r_depth - 4'd2;
                w_depth_n  = r_depth - 4'd1;
                w_active_n = 1'b0;
            end
            K_CLEAR: begin
                w_depth_n  = 4'd0;
                w_entry_n  = '0;
                w_active_n = 1'b0;
            end
            default: ;
        endcase
        if (w_wr_en) begin
            w_top_n = r_p_val;
        end else if (w_depth_n != 4'd0) begin
            w_top_n = r_stk[w_depth_n - 4'd1];
        end else begin
            w_top_n = '0;
        end
        w_disp_n = w_active_n ? w_entry_n : w_top_n;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_kv       <= 1'b0;
            r_kv_d     <= 1'b0;
            r_kc       <= 4'd0;
            r_key      <= 4'd0;
            for (int i = 0; i < 16; i++) r_stk[i] <= '0;
            r_depth    <= 4'd0;
            r_entry    <= '0;
            r_active   <= 1'b0;
            r_err      <= 2'd0;
            r_busy     <= 1'b0;
            r_op_done  <= 1'b0;
            r_disp     <= '0;
            r_disp_ent <= 1'b0;
            r_p_kind   <= K_NONE;
            r_p_val    <= '0;
            r_p_err    <= 2'd0;
`ifdef RPN_MUL_EN
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
`endif
        end else begin
            r_kv      <= i_key_valid;
            r_kv_d    <= r_kv;
            r_kc      <= i_key_code;
            r_op_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_kv && !r_kv_d) begin
                        r_key   <= r_kc;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_p_kind <= w_kind;
                    r_p_val  <= w_val;
                    r_p_err  <= w_errn;
`ifdef RPN_MUL_EN
                    if (w_is_mul) begin
                        r_p_val  <= '0;
                        r_mcand  <= w_op_a;
                        r_mplier <= w_op_b;
                        r_cnt    <= CW'(WIDTH);
                        r_state  <= S_MUL;
                    end else begin
                        r_state  <= S_DONE;
                    end
`else
                    r_state  <= S_DONE;
`endif
                end
`ifdef RPN_MUL_EN
                S_MUL: begin
                    if (r_mplier[0]) r_p_val <= r_p_val + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (w_wr_en) r_stk[w_wr_idx] <= r_p_val;
                    r_depth    <= w_depth_n;
                    r_entry    <= w_entry_n;
                    r_active   <= w_active_n;
                    r_err      <= r_p_err;
                    r_disp     <= w_disp_n;
                    r_disp_ent <= w_active_n;
                    r_op_done  <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_disp_value    = r_disp;
    assign o_disp_is_entry = r_disp_ent;
    assign o_depth         = r_depth;
    assign o_err           = r_err;
    assign o_busy          = r_busy;
    assign o_op_done       = r_op_done;

endmodule

// File: tb/tb_rpn_token_engine.sv
// Bench for rpn_token_engine (WIDTH=16, DEPTH=4): directed table, corner sequences and random
// keys checked against a queue-based calculator model. Follows RPN_MUL_EN like the design.
module tb_rpn_token_engine;
    localparam int     W    = 16;
    localparam int     D    = 4;
    localparam longint MAXV = (longint'(1) << W) - 1;
`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   key_code;
    logic         key_valid;
    logic [W-1:0] disp_value;
    logic         disp_is_entry;
    logic [3:0]   depth;
    logic [1:0]   err;
    logic         busy;
    logic         op_done;

    rpn_token_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_key_code      (key_code),
        .i_key_valid     (key_valid),
        .o_disp_value    (disp_value),
        .o_disp_is_entry (disp_is_entry),
        .o_depth         (depth),
        .o_err           (err),
        .o_busy          (busy),
        .o_op_done       (op_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    longint m_stk[$];
    longint m_entry;
    bit     m_active;
    int     m_err;

    typedef struct {
        int     key;
        longint disp;
        int     ent;
        int     dep;
        int     er;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_stk.delete();
        m_entry  = 0;
        m_active = 0;
        m_err    = 0;
    endfunction

    function automatic longint m_disp();
        if (m_active) return m_entry;
        if (m_stk.size() != 0) return m_stk[m_stk.size()-1];
        return 0;
    endfunction

    // Calculator rules applied directly with integer arithmetic.
    function automatic void m_apply(input int k);
        longint a, b, r, v;
        int need;
        if (k <= 9) begin
            if (!m_active) begin
                m_entry = k; m_active = 1; m_err = 0;
            end else if (m_entry * 10 + k > MAXV) begin
                m_err = 3;
            end else begin
                m_entry = m_entry * 10 + k; m_err = 0;
            end
            return;
        end
        case (k)
            10, 11, 12: begin
                if (k == 12 && !MUL_EN) begin
                    m_err = 0;
                    return;
                end
                need = m_active ? 1 : 2;
                if (m_stk.size() < need) begin
                    m_err = 2;
                end else begin
                    if (m_active) begin
                        b = m_entry; a = m_stk.pop_back();
                    end else begin
                        b = m_stk.pop_back(); a = m_stk.pop_back();
                    end
                    r = (k == 10) ? a + b : (k == 11) ? a - b : a * b;
                    m_stk.push_back(r & MAXV);
                    m_active = 0; m_err = 0;
                end
            end
            13: begin
                if (m_active) begin
                    m_active = 0; m_entry = 0; m_err = 0;
                end else if (m_stk.size() == 0) begin
                    m_err = 2;
                end else begin
                    void'(m_stk.pop_back()); m_err = 0;
                end
            end
            14: begin
                if (!m_active && m_stk.size() == 0) begin
                    m_err = 2;
                end else if (m_stk.size() == D) begin
                    m_err = 1;
                end else begin
                    v = m_active ? m_entry : m_stk[m_stk.size()-1];
                    m_stk.push_back(v);
                    m_active = 0; m_err = 0;
                end
            end
            default: begin
                m_reset();
            end
        endcase
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".disp"},  longint'(disp_value), m_disp());
        check({tag, ".ent"},   longint'(disp_is_entry), longint'(m_active));
        check({tag, ".depth"}, longint'(depth), longint'(m_stk.size()));
        check({tag, ".err"},   longint'(err), longint'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
    endtask

    // Hold key_valid for 'hold' cycles; measure accept-to-op_done latency and count pulses.
    task automatic press(input int k, input int hold, input string tag);
        int lat, dones, exp_lat;
        lat = -1; dones = 0;
        exp_lat = (k == 12 && MUL_EN) ? W + 3 : 3;
        @(negedge clk); key_code = 4'(k); key_valid = 1'b1;
        for (int c = 1; c <= hold + W + 10; c++) begin
            @(posedge clk); #1;
            if (op_done) begin
                dones++;
                if (lat < 0) lat = c - 1;
            end
            if (c == hold) key_valid = 1'b0;
        end
        m_apply(k);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".op_done_count"}, dones, 1);
        check_model(tag);
    endtask

    function automatic void add(input int k, input longint dv, input int en, input int dp, input int er);
        vec_t v;
        v.key = k; v.disp = dv; v.ent = en; v.dep = dp; v.er = er;
        tbl.push_back(v);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        string tag;

        // Entry and push
        add(1, 1, 1, 0, 0);     add(2, 12, 1, 0, 0);    add(3, 123, 1, 0, 0);
        add(14, 123, 0, 1, 0);  add(15, 0, 0, 0, 0);
        // Add and sub
        add(7, 7, 1, 0, 0);     add(14, 7, 0, 1, 0);    add(5, 5, 1, 1, 0);
        add(10, 12, 0, 1, 0);   add(2, 2, 1, 1, 0);     add(11, 10, 0, 1, 0);
        add(15, 0, 0, 0, 0);
        // Wrap, then entry overflow
        add(0, 0, 1, 0, 0);     add(14, 0, 0, 1, 0);    add(1, 1, 1, 1, 0);
        add(11, 65535, 0, 1, 0);
        add(6, 6, 1, 1, 0);     add(5, 65, 1, 1, 0);    add(5, 655, 1, 1, 0);
        add(3, 6553, 1, 1, 0);  add(6, 6553, 1, 1, 3);  add(15, 0, 0, 0, 0);
        // Stack overflow, underflow
        add(1, 1, 1, 0, 0);     add(14, 1, 0, 1, 0);    add(14, 1, 0, 2, 0);
        add(14, 1, 0, 3, 0);    add(14, 1, 0, 4, 0);    add(14, 1, 0, 4, 1);
        add(15, 0, 0, 0, 0);    add(10, 0, 0, 0, 2);    add(13, 0, 0, 0, 2);
        add(9, 9, 1, 0, 0);     add(13, 0, 0, 0, 0);
        // Multiply / unsupported C
        add(15, 0, 0, 0, 0);
        add(2, 2, 1, 0, 0);     add(5, 25, 1, 0, 0);    add(5, 255, 1, 0, 0);
        add(14, 255, 0, 1, 0);
`ifdef RPN_MUL_EN
        add(2, 2, 1, 1, 0);     add(5, 25, 1, 1, 0);    add(7, 257, 1, 1, 0);
        add(12, 65535, 0, 1, 0);
`else
        add(12, 255, 0, 1, 0);
`endif

        do_reset();
        check("reset.disp",  longint'(disp_value), 0);
        check("reset.ent",   longint'(disp_is_entry), 0);
        check("reset.depth", longint'(depth), 0);
        check("reset.err",   longint'(err), 0);
        check("reset.busy",  longint'(busy), 0);
        check("reset.done",  longint'(op_done), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            tag = $sformatf("tbl%0d", i);
            press(tbl[i].key, 1, tag);
            check({tag, ".exp_disp"},  longint'(disp_value), tbl[i].disp);
            check({tag, ".exp_ent"},   longint'(disp_is_entry), longint'(tbl[i].ent));
            check({tag, ".exp_depth"}, longint'(depth), longint'(tbl[i].dep));
            check({tag, ".exp_err"},   longint'(err), longint'(tbl[i].er));
        end

        // Level held for 50 cycles yields exactly one token.
        do_reset();
        press(9, 50, "held");

        // A fresh edge while C is executing is dropped.
        do_reset();
        press(3, 1, "bd_a");
        press(14, 1, "bd_b");
        press(4, 1, "bd_c");
        dones = 0;
        @(negedge clk); key_code = 4'd12; key_valid = 1'b1;
        for (int c = 1; c <= W + 30; c++) begin
            @(posedge clk); #1;
            if (op_done) dones++;
            if (c == 1) key_valid = 1'b0;
            if (c == 2) begin key_code = 4'd1; key_valid = 1'b1; end
            if (c == 5) key_valid = 1'b0;
        end
        m_apply(12);
        check("busy_drop.op_done_count", dones, 1);
        check_model("busy_drop");

`ifdef RPN_MUL_EN
        // Reset in the middle of a multiply: no commit, no op_done.
        do_reset();
        press(6, 1, "rm_a");
        press(14, 1, "rm_b");
        press(7, 1, "rm_c");
        dones = 0;
        @(negedge clk); key_code = 4'd12; key_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (op_done) dones++;
            if (c == 1) key_valid = 1'b0;
        end
        rst = 1'b1;
        m_reset();
        for (int c = 1; c <= W + 10; c++) begin
            @(posedge clk); #1;
            if (op_done) dones++;
            if (c == 2) rst = 1'b0;
        end
        check("mul_reset.op_done_count", dones, 0);
        check("mul_reset.busy", longint'(busy), 0);
        check_model("mul_reset");
`endif

        // Random tokens against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int r, k;
            r = int'($urandom_range(0, 99));
            if (r < 50)      k = int'($urandom_range(0, 9));
            else if (r < 54) k = 15;
            else             k = int'($urandom_range(10, 14));
            press(k, int'($urandom_range(1, 4)), $sformatf("rnd%0d_k%0d", i, k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
